inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
Produces the 32-bit RV32I instruction words that the NPC instruction decoder consumes. It accepts field-level commands (op, rd, rs1, imm) over a valid/ready handshake and encodes them into addi/ebreak/nop words. Encoded words are buffered in a small FIFO and streamed out over a second valid/ready handshake. It also tracks end of program: once an ebreak is accepted, it stops taking input and flags completion when that ebreak has been emitted. Used as a hardware program source for bring-up and testbenches.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2.
CNT_W, 32, width of emitted-instruction counter.

Ports:
clk  input  1  clock.
rst  input  1  asynchronous active-high reset.
in_valid  input  1  command valid.
in_ready  output  1  command accepted when in_valid && in_ready.
in_op  input  2  00 addi, 01 ebreak, 10 nop, 11 reserved.
in_rd  input  5  destination register (addi only).
in_rs1  input  5  source register (addi only).
in_imm  input  32  signed immediate (addi only).
out_valid  output  1  out_inst valid.
out_ready  input  1  consumer takes word when out_valid && out_ready.
out_inst  output  32  encoded instruction at FIFO head.
err  output  1  sticky; a command was rejected.
err_clr  input  1  synchronous clear of err.
done  output  1  ebreak has been emitted.
emit_cnt  output  CNT_W  count of words emitted, wraps at 2^CNT_W.

Behaviour:
- Reset (async, any time, including mid-stream): FIFO empty, pointers 0, state RUN, in_ready=1, out_valid=0, out_inst=0, err=0, done=0, emit_cnt=0.
- Encoding:
  - addi = {imm[11:0], rs1, 3'b000, rd, 7'b0010011}.
  - ebreak = 32'h00100073.
  - nop = 32'h00000013. For ebreak and nop, rd, rs1 and imm are ignored.
- Rejection: a command is consumed but not written to the FIFO, and err is set on the next edge, when:
  - op=11, or
  - op=00 and in_imm is not the sign-extension of in_imm[11:0] (valid range -2048..2047).
- err_clr clears err. If a rejection occurs in the same cycle as err_clr, err is set (set wins).
- in_ready = (state==RUN) && (count<DEPTH). The input is never accepted while the FIFO is full, even if a pop happens in the same cycle.
- FIFO behaviour:
  - out_valid = (count!=0); out_inst = head entry, or 0 when empty.
  - A word accepted at edge N is visible at out_inst after edge N if the FIFO was empty (1-cycle latency; no combinational in-to-out path).
  - Push and pop in the same cycle: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- emit_cnt increments on every pop.
- State machine:
  - RUN: accepting an ebreak moves to DRAIN. Other ops stay in RUN.
  - DRAIN: in_ready=0. Popping the ebreak word (always the last FIFO entry) moves to DONE.
  - DONE: in_ready=0, out_valid=0, done=1. Held until reset.
- out_inst must remain stable while out_valid && !out_ready.

Test Plan:
- addi rd=1 rs1=2 imm=5, out_ready=1 -> one cycle later out_valid=1, out_inst=0x00510093; emit_cnt=1.
- addi rd=31 rs1=0 imm=-1, then nop -> 0xFFF00F93 then 0x00000013, in order.
- addi imm=2048, then op=11 -> no output, err=1. Assert err_clr for one cycle -> err=0.
- out_ready=0 with DEPTH=4 -> after 4 accepted commands in_ready=0 and out_inst is held. Release out_ready -> 4 words drain in order; pointer wrap-around is exercised on the refill.
- nop, ebreak, then in_valid held high -> in_ready drops after the ebreak; words 0x00000013, 0x00100073 are emitted; done=1; emit_cnt=2; nothing further is accepted.
- Assert rst while in DRAIN with 2 words queued -> immediately out_valid=0, done=0, in_ready=1, emit_cnt=0.

Source files
------------

// File: rtl/inst_encoder.sv
// RV32I program source: encodes addi/ebreak/nop commands into a FIFO
// and streams the words out, flagging completion after ebreak leaves.
module inst_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             err,
  input  logic             err_clr,
  output logic             done,
  output logic [CNT_W-1:0] emit_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] OP_ADDI = 2'b00;
  localparam logic [1:0] OP_EBRK = 2'b01;
  localparam logic [1:0] OP_NOP  = 2'b10;

  logic [1:0]    state;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic          accept;
  logic          reject;
  logic          push;
  logic          pop;
  logic          imm_ok;
  logic [31:0]   word;

  // imm fits in 12 bits when bits 31..11 are all copies of the sign
  assign imm_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);

  always_comb begin
    word = 32'h0000_0013;
    unique case (in_op)
      OP_ADDI: word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b0010011};
      OP_EBRK: word = 32'h0010_0073;
      OP_NOP:  word = 32'h0000_0013;
      default: word = 32'h0000_0013;
    endcase
  end

  assign in_ready  = (state == S_RUN) && (count < FULL);
  assign accept    = in_valid && in_ready;
  assign reject    = accept &&
                     ((in_op == 2'b11) || ((in_op == OP_ADDI) && !imm_ok));
  assign push      = accept && !reject;
  assign out_valid = (count != '0) && (state != S_DONE);
  assign pop       = out_valid && out_ready;
  assign out_inst  = out_valid ? mem[rd_ptr] : 32'h0;
  assign done      = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err      <= 1'b0;
      emit_cnt <= '0;
    end else begin
      if (reject)       err <= 1'b1;
      else if (err_clr) err <= 1'b0;
      if (pop) emit_cnt <= emit_cnt + CNT_W'(1);
    end
  end

  // the ebreak is always the final FIFO entry once in DRAIN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_RUN;
    end else begin
      unique case (state)
        S_RUN:   if (push && in_op == OP_EBRK) state <= S_DRAIN;
        S_DRAIN: if (pop && count == (AW+1)'(1)) state <= S_DONE;
        S_DONE:  state <= S_DONE;
        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed scenarios plus random commands
// compared against a queue-based reference model.
module tb_inst_encoder;

  localparam int DEPTH = 4;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        err;
  logic        err_clr;
  logic        done;
  logic [31:0] emit_cnt;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_q[$];
  bit          m_err;
  bit          m_ended;
  bit          m_fin;
  logic [31:0] m_cnt;

  inst_encoder #(.DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .err(err), .err_clr(err_clr), .done(done), .emit_cnt(emit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(logic [31:0] imm);
    int s;
    s = $signed(imm);
    return (s >= -2048) && (s <= 2047);
  endfunction

  function automatic logic [31:0] enc(logic [1:0] op, logic [4:0] rd,
                                      logic [4:0] rs1, logic [31:0] imm);
    if (op == 2'b01) return EBREAK;
    if (op == 2'b10) return NOP;
    return ((imm & 32'hfff) << 20) + (32'(rs1) << 15) +
           (32'(rd) << 7) + 32'h13;
  endfunction

  function automatic bit m_rdy();
    return !m_ended && (m_q.size() < DEPTH);
  endfunction

  task automatic chk_outs(string tag);
    bit ov;
    ov = (m_q.size() > 0) && !m_fin;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".out_inst"}, out_inst, ov ? m_q[0] : 32'h0);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(m_rdy()));
    chk({tag, ".err"}, 32'(err), 32'(m_err));
    chk({tag, ".done"}, 32'(done), 32'(m_fin));
    chk({tag, ".emit_cnt"}, emit_cnt, m_cnt);
  endtask

  task automatic m_clear();
    m_q.delete();
    m_err = 0;
    m_ended = 0;
    m_fin = 0;
    m_cnt = 0;
  endtask

  task automatic step(string tag, bit v, logic [1:0] op, logic [4:0] rd,
                      logic [4:0] rs1, logic [31:0] imm, bit ordy, bit clr);
    bit acc, rej, pop;
    logic [31:0] w;
    in_valid = v; in_op = op; in_rd = rd; in_rs1 = rs1;
    in_imm = imm; out_ready = ordy; err_clr = clr;
    #1;
    chk({tag, ".ready_pre"}, 32'(in_ready), 32'(m_rdy()));
    acc = v && m_rdy();
    rej = acc && (op == 2'b11 || (op == 2'b00 && !in_range(imm)));
    pop = (m_q.size() > 0) && !m_fin && ordy;
    @(posedge clk);
    #1;
    if (pop) begin
      w = m_q.pop_front();
      m_cnt++;
      if (w == EBREAK) m_fin = 1;
    end
    if (acc && !rej) begin
      m_q.push_back(enc(op, rd, rs1, imm));
      if (op == 2'b01) m_ended = 1;
    end
    if (rej) m_err = 1;
    else if (clr) m_err = 0;
    chk_outs(tag);
  endtask

  task automatic idle(string tag, bit ordy);
    step(tag, 0, 2'b10, 0, 0, 0, ordy, 0);
  endtask

  // reset asserted mid-cycle: outputs must clear without a clock edge
  task automatic do_reset(string tag);
    #2;
    rst = 1;
    #1;
    m_clear();
    chk_outs(tag);
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    rst = 1; in_valid = 0; in_op = 0; in_rd = 0; in_rs1 = 0;
    in_imm = 0; out_ready = 0; err_clr = 0;
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    chk_outs("reset");
    rst = 0;

    step("a1", 1, 2'b00, 1, 2, 32'd5, 1, 0);
    chk("a1.const", out_inst, 32'h0051_0093);
    idle("a1.pop", 1);
    chk("a1.cnt", emit_cnt, 32'd1);

    step("a2", 1, 2'b00, 31, 0, 32'hffff_ffff, 0, 0);
    step("n2", 1, 2'b10, 7, 7, 32'h1234, 0, 0);
    chk("a2.const", out_inst, 32'hfff0_0f93);
    idle("a2.pop", 1);
    chk("n2.const", out_inst, NOP);
    idle("n2.pop", 1);

    step("big", 1, 2'b00, 3, 4, 32'd2048, 1, 0);
    step("rsv", 1, 2'b11, 3, 4, 32'd1, 1, 0);
    chk("rej.err", 32'(err), 32'd1);
    idle("rej.idle", 1);
    step("clr", 0, 2'b00, 0, 0, 0, 1, 1);
    chk("clr.err", 32'(err), 32'd0);
    step("setwin", 1, 2'b11, 0, 0, 0, 1, 1);
    chk("setwin.err", 32'(err), 32'd1);
    step("clr2", 0, 2'b00, 0, 0, 0, 1, 1);
    step("imax", 1, 2'b00, 5, 6, 32'd2047, 1, 0);
    step("imin", 1, 2'b00, 5, 6, -32'sd2048, 1, 0);
    step("ilow", 1, 2'b00, 5, 6, -32'sd2049, 1, 0);
    idle("bnd.drain", 1);

    for (int i = 0; i < 6; i++)
      step("fill", 1, 2'b00, 5'(i + 1), 5'(i), 32'(i * 100), 0, 0);
    chk("full.ready", 32'(in_ready), 32'd0);
    step("fullpp", 1, 2'b10, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) idle("drain", 1);
    for (int i = 0; i < 7; i++)
      step("refill", 1, 2'b00, 5'(i), 5'(i + 9), -32'sd7 * i, i[0], 0);
    for (int i = 0; i < 6; i++) idle("drain2", 1);

    do_reset("rst1");
    step("e.nop", 1, 2'b10, 0, 0, 0, 1, 0);
    step("e.ebrk", 1, 2'b01, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step("e.hold", 1, 2'b00, 1, 1, 1, 1, 0);
    chk("e.done", 32'(done), 32'd1);
    chk("e.cnt", emit_cnt, 32'd2);

    do_reset("rst2");
    step("d.nop", 1, 2'b10, 0, 0, 0, 0, 0);
    step("d.ebrk", 1, 2'b01, 0, 0, 0, 0, 0);
    idle("d.wait", 0);
    do_reset("rst_drain");
    chk("rd.ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 400; i++) begin
      int sel;
      logic [1:0] op;
      logic [31:0] imm;
      if (m_fin) do_reset("rnd.rst");
      sel = $urandom_range(0, 19);
      op = (sel < 12) ? 2'b00 : (sel < 16) ? 2'b10 :
           (sel < 19) ? 2'b11 : 2'b01;
      if ($urandom_range(0, 3) == 0) imm = $urandom;
      else imm = 32'($signed($urandom_range(0, 4200)) - 2100);
      step("rnd", $urandom_range(0, 3) != 0, op, 5'($urandom),
           5'($urandom), imm, $urandom_range(0, 9) < 6,
           $urandom_range(0, 7) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
